// File: rtl/scr1_mem_port_arb.sv
// rtl/scr1_mem_port_arb.sv - round-robin imem/dmem arbiter onto one memif target port
// Requests are locked until acked; in-order owner queue routes responses back.
module scr1_mem_port_arb #(
   parameter int AWIDTH      = 32,
   parameter int DWIDTH      = 32,
   parameter int OUTST_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imem_req,
   input  logic [AWIDTH-1:0] imem_addr,
   output logic              imem_req_ack,
   output logic [DWIDTH-1:0] imem_rdata,
   output logic [1:0]        imem_resp,
   input  logic              dmem_req,
   input  logic              dmem_cmd,
   input  logic [1:0]        dmem_width,
   input  logic [AWIDTH-1:0] dmem_addr,
   input  logic [DWIDTH-1:0] dmem_wdata,
   output logic              dmem_req_ack,
   output logic [DWIDTH-1:0] dmem_rdata,
   output logic [1:0]        dmem_resp,
   output logic              tgt_req,
   output logic              tgt_cmd,
   output logic [1:0]        tgt_width,
   output logic [AWIDTH-1:0] tgt_addr,
   output logic [DWIDTH-1:0] tgt_wdata,
   input  logic              tgt_req_ack,
   input  logic [DWIDTH-1:0] tgt_rdata,
   input  logic [1:0]        tgt_resp
);

   localparam int CNT_W = $clog2(OUTST_DEPTH + 1);
   localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;

   localparam logic [1:0] RESP_NOTRDY = 2'd0;
   localparam logic       CMD_RD      = 1'b0;
   localparam logic [1:0] WIDTH_WORD  = 2'd2;

   typedef enum logic {
      OWN_IMEM = 1'b0,
      OWN_DMEM = 1'b1
   } owner_e;

   owner_e           last_q;
   owner_e           lock_owner_q;
   logic             lock_vld_q;
   owner_e           sel;
   owner_e           head_owner;
   owner_e           owner_mem [OUTST_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             any_req;
   logic             q_full;
   logic             q_empty;
   logic             push;
   logic             pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUTST_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A locked owner keeps the grant so the target sees a stable request until ack.
   always_comb begin
      sel = OWN_IMEM;
      if (lock_vld_q) begin
         sel = lock_owner_q;
      end else if (imem_req && !dmem_req) begin
         sel = OWN_IMEM;
      end else if (dmem_req && !imem_req) begin
         sel = OWN_DMEM;
      end else if (imem_req && dmem_req) begin
         sel = (last_q == OWN_IMEM) ? OWN_DMEM : OWN_IMEM;
      end
   end

   assign any_req = imem_req | dmem_req;
   assign q_full  = (count_q == CNT_W'(OUTST_DEPTH));
   assign q_empty = (count_q == '0);
   assign tgt_req = any_req && !q_full;
   assign push    = tgt_req && tgt_req_ack;

   assign imem_req_ack = push && (sel == OWN_IMEM);
   assign dmem_req_ack = push && (sel == OWN_DMEM);

   // Fields are zeroed whenever no request is offered, so an idle port reads all-zero.
   always_comb begin
      tgt_cmd   = 1'b0;
      tgt_width = 2'd0;
      tgt_addr  = '0;
      tgt_wdata = '0;
      if (tgt_req) begin
         if (sel == OWN_DMEM) begin
            tgt_cmd   = dmem_cmd;
            tgt_width = dmem_width;
            tgt_addr  = dmem_addr;
            tgt_wdata = dmem_wdata;
         end else begin
            tgt_cmd   = CMD_RD;
            tgt_width = WIDTH_WORD;
            tgt_addr  = imem_addr;
            tgt_wdata = '0;
         end
      end
   end

   // Responses arriving with nothing outstanding are dropped rather than routed.
   assign head_owner = owner_mem[rd_ptr_q];
   assign pop        = (tgt_resp != RESP_NOTRDY) && !q_empty;

   always_comb begin
      imem_resp  = RESP_NOTRDY;
      imem_rdata = '0;
      dmem_resp  = RESP_NOTRDY;
      dmem_rdata = '0;
      if (pop) begin
         if (head_owner == OWN_DMEM) begin
            dmem_resp  = tgt_resp;
            dmem_rdata = tgt_rdata;
         end else begin
            imem_resp  = tgt_resp;
            imem_rdata = tgt_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         lock_vld_q   <= 1'b0;
         lock_owner_q <= OWN_IMEM;
         last_q       <= OWN_IMEM;
      end else begin
         if (push) begin
            last_q     <= sel;
            lock_vld_q <= 1'b0;
            wr_ptr_q   <= ptr_inc(wr_ptr_q);
         end else if (tgt_req) begin
            lock_vld_q   <= 1'b1;
            lock_owner_q <= sel;
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         owner_mem[wr_ptr_q] <= sel;
      end
   end

endmodule

// File: tb/tb_scr1_mem_port_arb.sv
// tb/tb_scr1_mem_port_arb.sv - self-checking bench for scr1_mem_port_arb
// Directed vector table, hand-written lock/reset sequences, then random traffic vs a queue model.
module tb_scr1_mem_port_arb;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 2;
   localparam logic [31:0] IADDR = 32'h0000_0200;
   localparam logic [31:0] DADDR = 32'h0000_1000;
   localparam logic [31:0] DWD   = 32'h0000_0055;

   logic          clk = 1'b0;
   logic          rst;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_req_ack;
   logic [DW-1:0] imem_rdata;
   logic [1:0]    imem_resp;
   logic          dmem_req;
   logic          dmem_cmd;
   logic [1:0]    dmem_width;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic          dmem_req_ack;
   logic [DW-1:0] dmem_rdata;
   logic [1:0]    dmem_resp;
   logic          tgt_req;
   logic          tgt_cmd;
   logic [1:0]    tgt_width;
   logic [AW-1:0] tgt_addr;
   logic [DW-1:0] tgt_wdata;
   logic          tgt_req_ack;
   logic [DW-1:0] tgt_rdata;
   logic [1:0]    tgt_resp;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   scr1_mem_port_arb #(.AWIDTH(AW), .DWIDTH(DW), .OUTST_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_req_ack(imem_req_ack),
      .imem_rdata(imem_rdata), .imem_resp(imem_resp),
      .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
      .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
      .tgt_req(tgt_req), .tgt_cmd(tgt_cmd), .tgt_width(tgt_width), .tgt_addr(tgt_addr),
      .tgt_wdata(tgt_wdata), .tgt_req_ack(tgt_req_ack), .tgt_rdata(tgt_rdata),
      .tgt_resp(tgt_resp)
   );

   typedef struct {
      logic        ireq, dreq, dcmd;
      logic [1:0]  dwidth;
      logic        ack;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic        treq, tcmd;
      logic [1:0]  twidth;
      logic [31:0] taddr;
      logic        ia, da;
      logic [1:0]  iresp, dresp;
      logic [31:0] irdata, drdata;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dc,
                        input logic [1:0] dw, input logic [31:0] da, input logic [31:0] dwd,
                        input logic ack, input logic [1:0] rsp, input logic [31:0] rd);
      imem_req = ir;  imem_addr = ia;
      dmem_req = dr;  dmem_cmd = dc; dmem_width = dw; dmem_addr = da; dmem_wdata = dwd;
      tgt_req_ack = ack; tgt_resp = rsp; tgt_rdata = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic treq, input logic tcmd,
                          input logic [1:0] tw, input logic [31:0] ta, input logic [31:0] twd,
                          input logic ia, input logic da, input logic [1:0] ir,
                          input logic [1:0] dr, input logic [31:0] ird, input logic [31:0] drd);
      chk({tag, ".tgt_req"}, 64'(tgt_req), 64'(treq));
      chk({tag, ".tgt_cmd"}, 64'(tgt_cmd), 64'(tcmd));
      chk({tag, ".tgt_width"}, 64'(tgt_width), 64'(tw));
      chk({tag, ".tgt_addr"}, 64'(tgt_addr), 64'(ta));
      chk({tag, ".tgt_wdata"}, 64'(tgt_wdata), 64'(twd));
      chk({tag, ".imem_req_ack"}, 64'(imem_req_ack), 64'(ia));
      chk({tag, ".dmem_req_ack"}, 64'(dmem_req_ack), 64'(da));
      chk({tag, ".imem_resp"}, 64'(imem_resp), 64'(ir));
      chk({tag, ".dmem_resp"}, 64'(dmem_resp), 64'(dr));
      chk({tag, ".imem_rdata"}, 64'(imem_rdata), 64'(ird));
      chk({tag, ".dmem_rdata"}, 64'(dmem_rdata), 64'(drd));
   endtask

   // Reference model state: owner queue (0=imem, 1=dmem), last grant, lock.
   bit m_q [$];
   bit m_last, m_lkv, m_lko;

   initial begin
      logic        r_ir, r_dr, r_dc, r_ack, r_rst, hold_i, hold_d;
      logic [1:0]  r_dw, r_rsp;
      logic [31:0] r_ia, r_da, r_dwd, r_rd;
      bit          full, e_treq, sel, e_ia, e_da, e_tcmd;
      logic [1:0]  e_tw, e_ir, e_dr;
      logic [31:0] e_ta, e_twd, e_ird, e_drd;

      //             ireq dreq dcmd dw  ack resp rdata         | treq tcmd tw taddr ia da ir dr irdata drdata
      vecs[0]  = '{0, 0, 0, 2, 0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0,  32'h0};
      vecs[1]  = '{1, 0, 0, 2, 1, 0, 32'h0,         1, 0, 2, IADDR, 1, 0, 0, 0, 32'h0,  32'h0};
      vecs[2]  = '{0, 0, 0, 2, 0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0,  32'h0};
      vecs[3]  = '{0, 0, 0, 2, 0, 1, 32'h13,        0, 0, 0, 32'h0, 0, 0, 1, 0, 32'h13, 32'h0};
      vecs[4]  = '{1, 1, 0, 2, 1, 0, 32'h0,         1, 0, 2, DADDR, 0, 1, 0, 0, 32'h0,  32'h0};
      vecs[5]  = '{1, 1, 0, 2, 1, 0, 32'h0,         1, 0, 2, IADDR, 1, 0, 0, 0, 32'h0,  32'h0};
      vecs[6]  = '{1, 1, 0, 2, 1, 1, 32'hAAAA0000,  0, 0, 0, 32'h0, 0, 0, 0, 1, 32'h0,  32'hAAAA0000};
      vecs[7]  = '{1, 1, 0, 2, 1, 1, 32'h13,        1, 0, 2, DADDR, 0, 1, 1, 0, 32'h13, 32'h0};
      vecs[8]  = '{1, 1, 0, 2, 1, 0, 32'h0,         1, 0, 2, IADDR, 1, 0, 0, 0, 32'h0,  32'h0};
      vecs[9]  = '{1, 1, 0, 2, 1, 2, 32'hAAAA0000,  0, 0, 0, 32'h0, 0, 0, 0, 2, 32'h0,  32'hAAAA0000};
      vecs[10] = '{0, 0, 0, 2, 0, 1, 32'h13,        0, 0, 0, 32'h0, 0, 0, 1, 0, 32'h13, 32'h0};
      vecs[11] = '{0, 0, 0, 2, 0, 1, 32'hDEAD,      0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0,  32'h0};

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].ireq, IADDR, vecs[i].dreq, vecs[i].dcmd, vecs[i].dwidth, DADDR, DWD,
               vecs[i].ack, vecs[i].resp, vecs[i].rdata);
         #1;
         chk_all($sformatf("vec%0d", i), vecs[i].treq, vecs[i].tcmd, vecs[i].twidth,
                 vecs[i].taddr, (vecs[i].taddr == DADDR) ? DWD : 32'h0, vecs[i].ia, vecs[i].da,
                 vecs[i].iresp, vecs[i].dresp, vecs[i].irdata, vecs[i].drdata);
         tick();
      end

      // Lock: make dmem the last grant, then hold an unacked dmem write while imem rises.
      drive(0, IADDR, 1, 0, 2, DADDR, DWD, 1, 0, 0);
      #1; chk("lock.pre_ack", 64'(dmem_req_ack), 64'd1);
      tick();
      drive(0, IADDR, 0, 0, 2, DADDR, DWD, 0, 1, 32'h77);
      #1; chk("lock.pre_resp", 64'(dmem_resp), 64'd1);
      tick();
      for (int c = 0; c < 3; c++) begin
         drive(c > 0, IADDR, 1, 1, 0, 32'h1004, 32'hA5, 0, 0, 0);
         #1;
         chk_all($sformatf("lock%0d", c), 1, 1, 0, 32'h1004, 32'hA5, 0, 0, 0, 0, 0, 0);
         tick();
      end
      drive(1, IADDR, 1, 1, 0, 32'h1004, 32'hA5, 1, 0, 0);
      #1; chk_all("lock_ack", 1, 1, 0, 32'h1004, 32'hA5, 0, 1, 0, 0, 0, 0);
      tick();
      drive(1, IADDR, 0, 0, 2, DADDR, DWD, 1, 0, 0);
      #1; chk_all("lock_after", 1, 0, 2, IADDR, 0, 1, 0, 0, 0, 0, 0);
      tick();
      drive(0, IADDR, 0, 0, 2, DADDR, DWD, 0, 1, 32'h11);
      #1; chk("lock.drain_d", 64'(dmem_resp), 64'd1);
      tick();
      drive(0, IADDR, 0, 0, 2, DADDR, DWD, 0, 1, 32'h22);
      #1; chk("lock.drain_i", 64'(imem_rdata), 64'h22);
      tick();

      // Reset with two outstanding, then stray responses must be dropped.
      drive(1, IADDR, 0, 0, 2, DADDR, DWD, 1, 0, 0);
      tick();
      drive(0, IADDR, 1, 0, 2, DADDR, DWD, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         drive(0, IADDR, 0, 0, 2, DADDR, DWD, 0, 1, 32'hBAD0 + c);
         #1;
         chk_all($sformatf("stray%0d", c), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         tick();
      end
      drive(1, IADDR, 1, 0, 2, DADDR, DWD, 1, 0, 0);
      #1; chk_all("rst_arb0", 1, 0, 2, DADDR, DWD, 0, 1, 0, 0, 0, 0);
      tick();
      #1; chk_all("rst_arb1", 1, 0, 2, IADDR, 0, 1, 0, 0, 0, 0, 0);
      tick();
      #1; chk_all("rst_full", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Random traffic against the queue model.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_q.delete(); m_last = 0; m_lkv = 0; m_lko = 0;
      hold_i = 0; hold_d = 0;
      r_ir = 0; r_ia = 0; r_dr = 0; r_dc = 0; r_dw = 0; r_da = 0; r_dwd = 0;
      for (int c = 0; c < 400; c++) begin
         if (!hold_i) begin
            r_ir = 1'($urandom_range(0, 1));
            r_ia = $urandom;
         end
         if (!hold_d) begin
            r_dr  = 1'($urandom_range(0, 1));
            r_dc  = 1'($urandom_range(0, 1));
            r_dw  = 2'($urandom_range(0, 2));
            r_da  = $urandom;
            r_dwd = $urandom;
         end
         r_ack = ($urandom_range(0, 9) < 6);
         r_rsp = ($urandom_range(0, 9) < 4) ? 2'($urandom_range(1, 2)) : 2'd0;
         r_rd  = $urandom;
         r_rst = ($urandom_range(0, 99) == 0);
         drive(r_ir, r_ia, r_dr, r_dc, r_dw, r_da, r_dwd, r_ack, r_rsp, r_rd);
         rst = r_rst;
         #1;
         full   = (m_q.size() == DEPTH);
         e_treq = (r_ir || r_dr) && !full;
         if (m_lkv)            sel = m_lko;
         else if (r_ir && !r_dr) sel = 0;
         else if (r_dr && !r_ir) sel = 1;
         else                    sel = !m_last;
         e_tcmd = 0; e_tw = 0; e_ta = 0; e_twd = 0;
         if (e_treq) begin
            e_tcmd = sel ? r_dc : 1'b0;
            e_tw   = sel ? r_dw : 2'd2;
            e_ta   = sel ? r_da : r_ia;
            e_twd  = sel ? r_dwd : 32'h0;
         end
         e_ia = e_treq && r_ack && !sel;
         e_da = e_treq && r_ack && sel;
         e_ir = 0; e_dr = 0; e_ird = 0; e_drd = 0;
         if (r_rsp != 0 && m_q.size() > 0) begin
            if (m_q[0]) begin e_dr = r_rsp; e_drd = r_rd; end
            else        begin e_ir = r_rsp; e_ird = r_rd; end
         end
         chk_all($sformatf("rnd%0d", c), e_treq, e_tcmd, e_tw, e_ta, e_twd, e_ia, e_da,
                 e_ir, e_dr, e_ird, e_drd);
         hold_i = r_ir && !e_ia;
         hold_d = r_dr && !e_da;
         tick();
         if (r_rst) begin
            m_q.delete(); m_last = 0; m_lkv = 0; m_lko = 0;
         end else begin
            if (r_rsp != 0 && m_q.size() > 0) void'(m_q.pop_front());
            if (e_treq && r_ack) begin
               m_q.push_back(sel);
               m_last = sel;
               m_lkv  = 0;
            end else if (e_treq) begin
               m_lkv = 1;
               m_lko = sel;
            end
         end
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
